// File: rtl/mole_draw_pkg.sv
// mole_draw_pkg: shared constants, state type and geometry helpers for the
// whack-a-mole drawing controller.
//   Colours      : BG, HOLE, MOLE, BORDER (3-bit vga_adapter palette indices)
//   State type   : state_t {CLEAR, IDLE, ERASE, DRAW}
//   Hole layout  : eight 31x31 holes on one row, 38 px pitch, starting at (8,110)
package mole_draw_pkg;

    localparam logic [2:0] BG     = 3'd0;
    localparam logic [2:0] HOLE   = 3'd1;
    localparam logic [2:0] MOLE   = 3'd6;
    localparam logic [2:0] BORDER = 3'd7;

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        IDLE  = 2'd1,
        ERASE = 2'd2,
        DRAW  = 2'd3
    } state_t;

    localparam int unsigned HOLE_X0    = 8;
    localparam int unsigned HOLE_PITCH = 38;
    localparam int unsigned HOLE_W     = 31;
    localparam int unsigned HOLE_Y0    = 110;
    localparam int unsigned HOLE_H     = 31;
    localparam int unsigned NUM_HOLES  = 8;

    // True when (px,py) lies inside any of the eight hole rectangles.
    function automatic logic in_hole_area(input logic [8:0] px, input logic [7:0] py);
        int unsigned xi;
        int unsigned yi;
        logic        hit;
        xi  = {23'd0, px};
        yi  = {24'd0, py};
        hit = 1'b0;
        if (yi >= HOLE_Y0 && yi < HOLE_Y0 + HOLE_H) begin
            for (int unsigned k = 0; k < NUM_HOLES; k++) begin
                if (xi >= HOLE_X0 + HOLE_PITCH * k && xi < HOLE_X0 + HOLE_PITCH * k + HOLE_W)
                    hit = 1'b1;
            end
        end
        return hit;
    endfunction

    // Left edge of hole k (1..8). k=0 is never used to start a pass.
    function automatic logic [8:0] hole_left(input logic [3:0] k);
        int unsigned v;
        v = HOLE_X0 + HOLE_PITCH * ({28'd0, k} - 32'd1);
        return v[8:0];
    endfunction

endpackage

// File: rtl/mole_draw_ctrl_rect_scan.sv
// rect_scan: raster counter over a rectangle (x fastest), shared by the clear,
// erase and draw passes.
//   clk, rst   : clock, asynchronous active-high reset
//   start      : capture x0/y0/w/h and move the position to (x0,y0)
//   en         : advance one pixel per cycle; holds at the last pixel
//   x0,y0,w,h  : rectangle origin and size (sampled on start)
//   cx,cy      : current pixel
//   last       : current pixel is the bottom-right corner
// Reset leaves the position at (0,0) with the extent RST_XL/RST_YL so that a
// full-screen scan can begin straight out of reset without a start pulse.
module rect_scan #(
    parameter int unsigned   XW     = 9,
    parameter int unsigned   YW     = 8,
    parameter logic [XW-1:0] RST_XL = '0,
    parameter logic [YW-1:0] RST_YL = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          en,
    input  logic [XW-1:0] x0,
    input  logic [YW-1:0] y0,
    input  logic [XW-1:0] w,
    input  logic [YW-1:0] h,
    output logic [XW-1:0] cx,
    output logic [YW-1:0] cy,
    output logic          last
);

    logic [XW-1:0] xs;
    logic [XW-1:0] xl;
    logic [YW-1:0] yl;

    assign last = (cx == xl) && (cy == yl);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cx <= '0;
            cy <= '0;
            xs <= '0;
            xl <= RST_XL;
            yl <= RST_YL;
        end else if (start) begin
            cx <= x0;
            cy <= y0;
            xs <= x0;
            xl <= x0 + w - XW'(1);
            yl <= y0 + h - YW'(1);
        end else if (en && !last) begin
            if (cx == xl) begin
                cx <= xs;
                cy <= cy + YW'(1);
            end else begin
                cx <= cx + XW'(1);
            end
        end
    end

endmodule

// File: rtl/mole_draw_ctrl.sv
// mole_draw_ctrl: drives a vga_adapter to clear the screen after reset and
// then move a single mole between eight holes on request.
//   clk, rst          : clock, asynchronous active-high reset
//   req, hole         : move request (sampled while ready) and target hole
//                       (0 = none, 1..8 = hole, 9..15 treated as 0)
//   ready, done       : idle/accepting flag, one-cycle completion pulse
//   x, y, color, plot : registered pixel write port (one pixel per cycle)
// Build option: define MOLE_DRAW_BORDER_EN to paint a one-pixel screen border
// in BORDER colour during the clear pass.
module mole_draw_ctrl #(
    parameter int unsigned SCR_W = 320,
    parameter int unsigned SCR_H = 240
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req,
    input  logic [3:0] hole,
    output logic       ready,
    output logic       done,
    output logic [8:0] x,
    output logic [7:0] y,
    output logic [2:0] color,
    output logic       plot
);

    import mole_draw_pkg::*;

    localparam logic [8:0] XMAX = 9'(SCR_W - 1);
    localparam logic [7:0] YMAX = 8'(SCR_H - 1);

    state_t     state, state_n;
    logic [3:0] cur_hole, cur_hole_n;
    logic [3:0] new_hole, new_hole_n;
    logic       done_pend, done_pend_n;
    logic [3:0] hole_eff;
    logic [3:0] ld_hole;
    logic       scan_start;
    logic       scan_en;
    logic [8:0] cx;
    logic [7:0] cy;
    logic       last;
    logic [2:0] pix_color;

    assign hole_eff = (hole > 4'd8) ? '0 : hole;
    assign scan_en  = (state != IDLE);
    // done_pend marks the cycle between a pass ending and its done pulse;
    // holding ready low there keeps ready from rising before done.
    assign ready    = (state == IDLE) && !done_pend;

    rect_scan #(
        .XW     (9),
        .YW     (8),
        .RST_XL (XMAX),
        .RST_YL (YMAX)
    ) u_scan (
        .clk   (clk),
        .rst   (rst),
        .start (scan_start),
        .en    (scan_en),
        .x0    (hole_left(ld_hole)),
        .y0    (8'(HOLE_Y0)),
        .w     (9'(HOLE_W)),
        .h     (8'(HOLE_H)),
        .cx    (cx),
        .cy    (cy),
        .last  (last)
    );

    // The next rectangle is loaded on the same edge the previous pass emits
    // its last pixel, so ERASE flows into DRAW without a gap.
    always_comb begin
        state_n     = state;
        cur_hole_n  = cur_hole;
        new_hole_n  = new_hole;
        done_pend_n = 1'b0;
        scan_start  = 1'b0;
        ld_hole     = new_hole;
        unique case (state)
            CLEAR: begin
                if (last) begin
                    state_n     = IDLE;
                    done_pend_n = 1'b1;
                end
            end
            IDLE: begin
                if (req && ready) begin
                    new_hole_n = hole_eff;
                    if (cur_hole != 4'd0) begin
                        ld_hole    = cur_hole;
                        scan_start = 1'b1;
                        state_n    = ERASE;
                    end else if (hole_eff != 4'd0) begin
                        ld_hole    = hole_eff;
                        scan_start = 1'b1;
                        state_n    = DRAW;
                    end else begin
                        done_pend_n = 1'b1;
                    end
                end
            end
            ERASE: begin
                if (last) begin
                    if (new_hole != 4'd0) begin
                        ld_hole    = new_hole;
                        scan_start = 1'b1;
                        state_n    = DRAW;
                    end else begin
                        cur_hole_n  = '0;
                        state_n     = IDLE;
                        done_pend_n = 1'b1;
                    end
                end
            end
            DRAW: begin
                if (last) begin
                    cur_hole_n  = new_hole;
                    state_n     = IDLE;
                    done_pend_n = 1'b1;
                end
            end
            default: state_n = CLEAR;
        endcase
    end

    always_comb begin
        pix_color = BG;
        unique case (state)
            CLEAR: begin
                pix_color = in_hole_area(cx, cy) ? HOLE : BG;
`ifdef MOLE_DRAW_BORDER_EN
                if (cx == '0 || cx == XMAX || cy == '0 || cy == YMAX)
                    pix_color = BORDER;
`endif
            end
            ERASE:   pix_color = HOLE;
            DRAW:    pix_color = MOLE;
            default: pix_color = BG;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= CLEAR;
            cur_hole  <= '0;
            new_hole  <= '0;
            done_pend <= 1'b0;
            done      <= 1'b0;
            plot      <= 1'b0;
            x         <= '0;
            y         <= '0;
            color     <= '0;
        end else begin
            state     <= state_n;
            cur_hole  <= cur_hole_n;
            new_hole  <= new_hole_n;
            done_pend <= done_pend_n;
            done      <= done_pend;
            plot      <= scan_en;
            x         <= cx;
            y         <= cy;
            color     <= pix_color;
        end
    end

endmodule

// File: doc/mole_draw_ctrl.md
MOLE_DRAW_CTRL -- requirements
Module: mole_draw_ctrl

Interface
- REQ-001: Parameter SCR_W, default 320, screen width in pixels SHALL set the clear-pass x range 0..SCR_W-1.
- REQ-002: Parameter SCR_H, default 240, screen height in pixels SHALL set the clear-pass y range 0..SCR_H-1.
- REQ-003: clk  input  1  sole clock; all state SHALL update on its rising edge.
- REQ-004: rst  input  1  asynchronous, active-high reset.
- REQ-005: req  input  1  one-cycle request to move the mole; SHALL be sampled only while ready=1.
- REQ-006: hole  input  4  target hole; 0 = no mole, 1..8 = hole k, 9..15 SHALL be treated as 0.
- REQ-007: ready  output  1  high when idle and a req will be accepted.
- REQ-008: done  output  1  one-cycle pulse after the last pixel of a clear or move.
- REQ-009: x  output  9  pixel x to the vga_adapter.
- REQ-010: y  output  8  pixel y to the vga_adapter.
- REQ-011: color  output  3  pixel colour to the vga_adapter.
- REQ-012: plot  output  1  write strobe; exactly one pixel per cycle while high.

Function
- REQ-013: FSM states SHALL be CLEAR, IDLE, ERASE, DRAW; x, y, color and plot SHALL all be registered.
- REQ-014: CLEAR SHALL raster-scan y 0..SCR_H-1, x 0..SCR_W-1 (x fastest), one pixel per cycle, 76800 cycles at defaults.
- REQ-015: In CLEAR, colour SHALL be HOLE (3'd1) when 110<=y<=140 and x is within [8+38k, 38+38k] for some k in 0..7, else BG (3'd0).
- REQ-016: CLEAR -> IDLE after pixel (SCR_W-1, SCR_H-1); done SHALL pulse in the first IDLE cycle.
- REQ-017: In IDLE, ready=1 and plot=0; req=1 SHALL latch hole into new_hole and deassert ready on the next cycle.
- REQ-018: Accepted req -> ERASE if cur_hole!=0, else -> DRAW if new_hole!=0, else -> IDLE with a done pulse and no plots.
- REQ-019: ERASE SHALL repaint the 31x31 rectangle of cur_hole (x 8+38(k-1)..38+38(k-1), y 110..140) in HOLE colour, 961 cycles.
- REQ-020: After ERASE: -> DRAW if new_hole!=0, else -> IDLE.
- REQ-021: DRAW SHALL paint the new_hole rectangle in MOLE colour (3'd6), 961 cycles; then cur_hole<=new_hole, -> IDLE, done pulse.
- REQ-022: When new_hole=0, cur_hole SHALL become 0 at the ERASE->IDLE transition.
- REQ-023: First plot SHALL occur exactly 1 cycle after the acceptance edge; plot SHALL be continuous (no gaps) within a pass and between ERASE and DRAW.
- REQ-024: req while ready=0 SHALL be ignored (not queued); new_hole equal to cur_hole SHALL still run ERASE then DRAW.
- REQ-025: Counter arithmetic SHALL be unsigned with no wrap beyond the rectangle/screen end; x never exceeds SCR_W-1, y never exceeds SCR_H-1.

Reset
- REQ-026: While rst=1: plot=0, ready=0, done=0, x=0, y=0, color=0, cur_hole=0, new_hole=0, state=CLEAR with counters at 0.
- REQ-027: On rst release, a full CLEAR SHALL start automatically; first plot at (0,0) on the first rising edge after release.
- REQ-028: rst asserted mid-pass SHALL abort the pass immediately; no partial completion, no done pulse.

Configuration
- REQ-029: With MOLE_DRAW_BORDER_EN defined, CLEAR SHALL paint pixels with x=0, x=SCR_W-1, y=0 or y=SCR_H-1 in BORDER colour (3'd7), overriding REQ-015.
- REQ-030: Without MOLE_DRAW_BORDER_EN, CLEAR colours SHALL follow REQ-015 only; all other behaviour is identical.

Structure
- REQ-031: Package mole_draw_pkg SHALL hold colour constants (BG, HOLE, MOLE, BORDER), the state enum, HOLE_X0=8, HOLE_PITCH=38, HOLE_W=31, HOLE_Y0=110, HOLE_H=31, NUM_HOLES=8.
- REQ-032: Sub-module rect_scan SHALL generate the x/y raster over (x0, y0, w, h) with start/last signals, shared by CLEAR, ERASE and DRAW.

Verification
- REQ-033: Release rst -> 76800 consecutive plots, (0,0) first, (319,239) last; (8,110)=1, (7,110)=0, (39,125)=0; done one cycle later.
- REQ-034: IDLE, cur_hole=0, req with hole=3 -> 961 plots, x 84..114, y 110..140, colour 6; done; cur_hole=3.
- REQ-035: cur_hole=3, req with hole=8 -> 961 plots colour 1 at x 84..114, then 961 plots colour 6 at x 274..304, no gap; single done.
- REQ-036: cur_hole=5, req with hole=12 -> 961 plots colour 1 at x 160..190, cur_hole=0; req during ERASE ignored; ready only after done.
- REQ-037: rst pulse at plot 500 of DRAW -> outputs 0 during rst, CLEAR restarts at (0,0), no done before CLEAR completes.
- REQ-038: With MOLE_DRAW_BORDER_EN: (0,120)=7, (319,0)=7, (8,110)=1; without: (0,120)=0.
